tof_frame_buffer: RTL and testbench

//  Collects 8x8-zone distance frames from 8 ToF sensors into a 512-entry frame memory.

---
 rtl/tof_pkg.sv | 21 ++
 rtl/tof_frame_ram.sv | 24 ++
 rtl/tof_frame_buffer.sv | 94 +++++++++
 tb/tb_tof_frame_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tof_pkg.sv
// Shared types and sizes for the ToF frame buffer.
// Zone address is {sens, row, col}, 9 bits.
package tof_pkg;
    localparam int NUM_SENS = 8;
    localparam int ZONES    = 64;
    localparam int DATA_W   = 16;
    localparam int SENS_W   = 3;
    localparam int ZONE_W   = 6;
    localparam int ADDR_W   = 9;

    typedef struct packed {
        logic [2:0] sens;
        logic [2:0] row;
        logic [2:0] col;
    } tof_addr_t;

    typedef enum logic {
        FILL,
        LOCKED
    } fb_state_t;
endpackage

// File: rtl/tof_frame_ram.sv
// Simple dual-port frame memory: one write port, one registered read port.
// No reset so it maps onto block RAM.
module tof_frame_ram
    import tof_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/tof_frame_buffer.sv
// Gathers one 8x8 frame from each of 8 ToF sensors, then locks the
// set for read-out until the consumer releases it.
module tof_frame_buffer
    import tof_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SENS_W-1:0]   s_sens,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    output logic                drdy,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                frame_release,
    output logic [NUM_SENS-1:0] sens_done,
    output logic                frame_err
);
    fb_state_t           state;
    fb_state_t           state_nxt;
    logic [ZONE_W-1:0]   zone_cnt [NUM_SENS];
    logic [ZONE_W-1:0]   zc;
    logic                accept;
    logic                at_end;
    logic                good_end;
    logic                bad_end;
    logic [NUM_SENS-1:0] done_set;
    tof_addr_t           wr_addr;

    assign zc       = zone_cnt[s_sens];
    assign accept   = s_valid && s_ready;
    assign at_end   = (zc == ZONE_W'(ZONES - 1));
    assign good_end = accept && at_end && s_last;
    assign bad_end  = accept && (at_end != s_last);
    assign wr_addr  = {s_sens, zc};

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        drdy      = 1'b0;
        done_set  = sens_done;
        if (good_end) begin
            done_set[s_sens] = 1'b1;
        end
        unique case (state)
            FILL: begin
                s_ready = !sens_done[s_sens];
                if (&done_set) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                drdy = 1'b1;
                if (frame_release) begin
                    state_nxt = FILL;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            sens_done <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_SENS; i++) begin
                zone_cnt[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            frame_err <= bad_end;
            if (state == LOCKED && frame_release) begin
                sens_done <= '0;
            end else begin
                sens_done <= done_set;
            end
            // Any s_last or zone 63 ends the frame, good or bad.
            if (accept) begin
                zone_cnt[s_sens] <= (at_end || s_last) ? '0 : zc + 1'b1;
            end
        end
    end

    tof_frame_ram u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_addr),
        .wdata (s_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_tof_frame_buffer.sv
// Directed bench for tof_frame_buffer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_tof_frame_buffer;
    import tof_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [SENS_W-1:0]   s_sens = '0;
    logic [DATA_W-1:0]   s_data = '0;
    logic                s_last = 1'b0;
    logic                drdy;
    logic [ADDR_W-1:0]   rd_addr = '0;
    logic [DATA_W-1:0]   rd_data;
    logic                frame_release = 1'b0;
    logic [NUM_SENS-1:0] sens_done;
    logic                frame_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    tof_frame_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_sens        (s_sens),
        .s_data        (s_data),
        .s_last        (s_last),
        .drdy          (drdy),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_release (frame_release),
        .sens_done     (sens_done),
        .frame_err     (frame_err)
    );

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int s, input int d, input bit l);
        s_sens  = 3'(s);
        s_data  = 16'(d);
        s_last  = l;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic read(input int a, output logic [DATA_W-1:0] d);
        rd_addr = 9'(a);
        @(posedge clk);
        #1;
        d = rd_data;
    endtask

    task automatic fill_all(input int base, output bit early, output bit err);
        early = 1'b0;
        err   = 1'b0;
        for (int i = 0; i < 512; i++) begin
            if (drdy !== 1'b0) early = 1'b1;
            push(i % 8, base + (i % 8) * 64 + i / 8, (i / 8) == 63);
            if (frame_err !== 1'b0) err = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (drdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drdy: got %b want 0", drdy);
        end
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", s_ready);
        end
        tests_run++;
        if (sens_done !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_done: got %h want 00", sens_done);
        end
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err: got %b want 0", frame_err);
        end
    endtask

    task automatic test_full_fill();
        bit early, err;
        logic [DATA_W-1:0] d;
        fill_all(0, early, err);
        tests_run++;
        if (early) begin
            tests_failed++;
            $display("FAIL fill_early: drdy high before 512th accept");
        end
        tests_run++;
        if (err) begin
            tests_failed++;
            $display("FAIL fill_err: frame_err pulsed on clean fill");
        end
        tests_run++;
        if (drdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_drdy: got %b want 1", drdy);
        end
        tests_run++;
        if (sens_done !== 8'hFF) begin
            tests_failed++;
            $display("FAIL fill_done: got %h want ff", sens_done);
        end
        s_sens  = 3'd0;
        s_valid = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_ready: got %b want 0", s_ready);
        end
        s_valid = 1'b0;
        read(9'h0A3, d);
        tests_run++;
        if (d !== 16'h00A3) begin
            tests_failed++;
            $display("FAIL fill_rd0a3: got %h want 00a3", d);
        end
        read(9'h1FF, d);
        tests_run++;
        if (d !== 16'h01FF) begin
            tests_failed++;
            $display("FAIL fill_rd1ff: got %h want 01ff", d);
        end
    endtask

    task automatic test_release();
        logic [DATA_W-1:0] d;
        s_sens        = 3'd0;
        s_data        = 16'hDEAD;
        s_valid       = 1'b1;
        frame_release = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rel_ready_locked: got %b want 0", s_ready);
        end
        @(posedge clk);
        #1;
        frame_release = 1'b0;
        s_valid       = 1'b0;
        tests_run++;
        if (drdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rel_drdy: got %b want 0", drdy);
        end
        tests_run++;
        if (sens_done !== 8'h00) begin
            tests_failed++;
            $display("FAIL rel_done: got %h want 00", sens_done);
        end
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rel_ready_fill: got %b want 1", s_ready);
        end
        push(0, 16'hBEEF, 1'b0);
        push(0, 16'h1234, 1'b0);
        read(9'h000, d);
        tests_run++;
        if (d !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL rel_over0: got %h want beef", d);
        end
        read(9'h001, d);
        tests_run++;
        if (d !== 16'h1234) begin
            tests_failed++;
            $display("FAIL rel_over1: got %h want 1234", d);
        end
    endtask

    task automatic test_frame_err();
        logic [DATA_W-1:0] d;
        for (int z = 0; z < 10; z++) push(3, 16'h3000 + z, 1'b0);
        push(3, 16'h300A, 1'b1);
        tests_run++;
        if (frame_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_early_last: got %b want 1", frame_err);
        end
        tests_run++;
        if (sens_done[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_done3: got %b want 0", sens_done[3]);
        end
        idle(1);
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_pulse: got %b want 0", frame_err);
        end
        push(3, 16'h3AAA, 1'b0);
        read(9'h0C0, d);
        tests_run++;
        if (d !== 16'h3AAA) begin
            tests_failed++;
            $display("FAIL err_retry0: got %h want 3aaa", d);
        end
        read(9'h0C1, d);
        tests_run++;
        if (d !== 16'h3001) begin
            tests_failed++;
            $display("FAIL err_stale1: got %h want 3001", d);
        end
        for (int z = 0; z < 64; z++) push(6, 16'h6000 + z, 1'b0);
        tests_run++;
        if (frame_err !== 1'b1 || sens_done[6] !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_no_last: err=%b done6=%b want 1/0",
                     frame_err, sens_done[6]);
        end
    endtask

    task automatic test_ready_mask();
        for (int z = 0; z < 64; z++) push(5, 16'h5000 + z, z == 63);
        tests_run++;
        if (sens_done !== 8'h20) begin
            tests_failed++;
            $display("FAIL mask_done: got %h want 20", sens_done);
        end
        s_sens  = 3'd5;
        s_valid = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_ready5: got %b want 0", s_ready);
        end
        s_sens = 3'd4;
        #1;
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mask_ready4: got %b want 1", s_ready);
        end
        s_valid = 1'b0;
        idle(1);
        frame_release = 1'b1;
        idle(1);
        frame_release = 1'b0;
        tests_run++;
        if (sens_done !== 8'h20 || drdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rel_in_fill: done=%h drdy=%b want 20/0",
                     sens_done, drdy);
        end
    endtask

    task automatic test_reset_midfill();
        bit early, err;
        logic [DATA_W-1:0] d;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) push(i % 8, 16'h4000 + i, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        tests_run++;
        if (sens_done !== 8'h00 || drdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: done=%h drdy=%b want 00/0",
                     sens_done, drdy);
        end
        fill_all(16'h8000, early, err);
        tests_run++;
        if (early) begin
            tests_failed++;
            $display("FAIL mid_early: drdy high before 512 fresh accepts");
        end
        tests_run++;
        if (drdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_drdy: got %b want 1", drdy);
        end
        read(9'h1C5, d);
        tests_run++;
        if (d !== 16'h81C5) begin
            tests_failed++;
            $display("FAIL mid_rd1c5: got %h want 81c5", d);
        end
    endtask

    initial begin
        test_reset();
        test_full_fill();
        test_release();
        test_frame_err();
        test_ready_mask();
        test_reset_midfill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
